// File: rtl/mem_pkg.sv
// mem_pkg: shared line/address widths and the request FSM encoding for data_memory.
package mem_pkg;
    localparam int LINE_W        = 256;
    localparam int ADDR_W        = 32;
    localparam int LINE_OFFSET_W = 5;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} mem_state_e;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: single-port line storage, synchronous write and combinational read.
// Contents are never reset so memory survives a controller reset.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              Clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);
    logic [LINE_W-1:0] mem [DEPTH];
    always_ff @(posedge Clk_i)
        if (we) mem[idx] <= wdata;
    assign rdata = mem[idx];
endmodule

// File: rtl/data_memory.sv
// data_memory: fixed-latency main-memory responder for cache line refill/write-back.
// Optional DATA_MEMORY_STATS_EN adds read/write completion counters.
module data_memory
    import mem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic              Clk_i,
    input  logic              Rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
`ifdef DATA_MEMORY_STATS_EN
    ,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    mem_state_e        state;
    logic [7:0]        cnt;
    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata;
    logic              done;
    logic              unused_addr;
    assign unused_addr = ^{addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W], addr_i[LINE_OFFSET_W-1:0]};
    // done marks the edge entering ACK, where the access itself happens
    assign done  = state == WAIT && cnt == 8'(LATENCY - 1);
    assign ack_o = state == ACK;
    mem_line_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .Clk_i (Clk_i),
        .we    (done && wr_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );
    always_ff @(posedge Clk_i or posedge Rst_i)
        if (Rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            data_o  <= '0;
        end else if (state == IDLE && enable_i) begin
            state   <= WAIT;
            cnt     <= '0;
            wr_q    <= write_i;
            idx_q   <= addr_i[LINE_OFFSET_W +: IDX_W];
            wdata_q <= data_i;
        end else if (done) begin
            state <= ACK;
            if (!wr_q) data_o <= rdata;
        end else if (state == WAIT) begin
            cnt <= cnt + 8'd1;
        end else if (state == ACK) begin
            state <= IDLE;
        end
`ifdef DATA_MEMORY_STATS_EN
    always_ff @(posedge Clk_i or posedge Rst_i)
        if (Rst_i) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else if (done) begin
            rd_count_o <= rd_count_o + 32'(!wr_q);
            wr_count_o <= wr_count_o + 32'(wr_q);
        end
`endif
endmodule
